// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and defaults for the bit-serial add sequencer.
package serial_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_fulladder.sv
// Gate-level one-bit full adder; the shared datapath cell of the serial adder.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic ab_x;
  logic ab_a;
  logic c_a;

  assign ab_x = a ^ b;
  assign sum  = ab_x ^ cin;
  assign ab_a = a & b;
  assign c_a  = ab_x & cin;
  assign cout = ab_a | c_a;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer: one full-adder cell, LSB first, start/done handshake.
// Optional SERIAL_ADD_SUB_EN adds a 'sub' port for a - b.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  sum_sh_q, sum_sh_d;
  logic              carry_q, carry_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;

  logic              fa_sum;
  logic              fa_cout;

  fulladder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d = a;
`ifdef SERIAL_ADD_SUB_EN
          // Subtract as a + ~b + 1; cin is ignored in that mode.
          b_sh_d  = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
`else
          b_sh_d  = b;
          carry_d = cin;
`endif
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = {fa_sum, sum_sh_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule
